br_resolve_ctrl: RTL and testbench
==================================

Name: br_resolve_ctrl

Overview:
- Sequences the fetch-stage branch predictor against execute-stage branch resolution.
- Keeps an in-order queue of in-flight predictions (branch PC, predicted taken, predicted next PC). Compares each prediction with the actual outcome when execute resolves it.
- Drives the predictor training strobes (br_sig / miss_pred) and the pipeline redirect/flush sequence. Throttles fetch when the queue is full.

Parameters:
- DEPTH, 4, max in-flight predictions (power of two, >=2)
- FLUSH_CYCLES, 2, cycles flush_o is held after a mispredict (>=1)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- pred_valid_i  in  1  fetch issued a predicted branch/JAL this cycle
- pred_taken_i  in  1  predictor taken decision
- pred_pc_i  in  32  PC of the branch instruction
- pred_target_i  in  32  predicted next PC (target if taken, pc+4 otherwise)
- pred_ready_o  out  1  queue can accept; fetch stalls when low
- res_valid_i  in  1  execute resolved the oldest in-flight branch
- res_taken_i  in  1  actual taken outcome
- res_target_i  in  32  actual next PC
- upd_valid_o  out  1  predictor training strobe (to br_sig_i)
- upd_miss_o  out  1  mispredict flag (to miss_pred_i)
- redirect_o  out  1  one-cycle fetch redirect pulse
- redirect_pc_o  out  32  fetch redirect address
- flush_o  out  1  kill younger instructions in IF/ID/EX
- inflight_o  out  $clog2(DEPTH+1)  current queue occupancy

Behaviour:
- Reset (async, reset_n low): queue empty, state RUN, flush counter 0, all outputs 0 except pred_ready_o = 1. Reset mid-flush aborts the flush immediately.
- Queue: circular FIFO with rd/wr pointers and count.
  - Push when pred_valid_i && pred_ready_o.
  - Pop when res_valid_i in RUN with count>0.
- pred_ready_o = (state==RUN) && (count<DEPTH). This is combinational from registered state.
  - When full, there is no same-cycle bypass: a pop does not make pred_ready_o high in the same cycle.
- FSM states RUN and FLUSH.
- RUN, cycle N, res_valid_i=1, count>0: entry E = queue head.
  - Mispredict = (res_taken_i != E.taken) || (res_target_i != E.target).
  - Cycle N+1 (all registered): upd_valid_o=1 and upd_miss_o=mispredict, for one cycle.
  - Correct prediction: pop E; a simultaneous push is allowed; count stays consistent.
  - Mispredict: at the N->N+1 edge, clear the whole queue (count=0) and drop any same-cycle push.
    - Cycle N+1: redirect_o=1 and redirect_pc_o=res_target_i for one cycle. flush_o=1 and state=FLUSH.
    - flush_o stays high for cycles N+1..N+FLUSH_CYCLES. State returns to RUN at N+FLUSH_CYCLES+1.
- FLUSH: pred_valid_i and res_valid_i are ignored. pred_ready_o=0.
- res_valid_i with count==0 is a protocol error: it is ignored and no update is emitted.
- redirect_pc_o holds its last value when redirect_o=0.
- Widths: 32-bit equality compare only; no arithmetic on PCs. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro BR_CTRL_STATS_EN.
- Defined:
  - Adds outputs stat_resolved_o[31:0] and stat_miss_o[31:0], both reset to 0.
  - Each increments on the cycle upd_valid_o / (upd_valid_o && upd_miss_o) is high.
  - Both saturate at 32'hFFFF_FFFF.
  - Adds a sticky output stat_err_o, set by res_valid_i with an empty queue.
- Undefined: the stat ports and their logic are absent. Core behaviour is unchanged.

Test Plan:
- Push pc=0x100, taken=1, target=0x140, then resolve taken=1, target=0x140 -> next cycle upd_valid_o=1, upd_miss_o=0, redirect_o=0, inflight_o back to 0.
- Push 3 entries, resolve the first with target 0x104 vs predicted 0x140 -> upd_miss_o=1, redirect_o=1, redirect_pc_o=0x104, flush_o high exactly 2 cycles, inflight_o=0, pred_ready_o=0 during flush and 1 after.
- Push 4 entries (DEPTH=4) -> pred_ready_o=0. Pop with simultaneous pred_valid_i -> push not accepted that cycle; accepted the following cycle; inflight_o=4.
- Mispredict resolve with pred_valid_i high in the same cycle -> push dropped, inflight_o=0. res_valid_i during FLUSH -> no upd_valid_o.
- Assert reset_n low during the first flush cycle -> flush_o, redirect_o, upd_valid_o drop to 0 immediately; inflight_o=0; pred_ready_o=1.
- With BR_CTRL_STATS_EN: 5 resolves, 2 mispredicts, 1 resolve on an empty queue -> stat_resolved_o=5, stat_miss_o=2, stat_err_o=1.

Source files
------------

// File: rtl/br_resolve_if.sv
// Handshake bundle between fetch/execute and the branch-resolution controller.
// Size DEPTH to match the controller so inflight_o widths agree.
interface br_resolve_if #(
    parameter int DEPTH = 4
);
    logic                         pred_valid_i;
    logic                         pred_taken_i;
    logic [31:0]                  pred_pc_i;
    logic [31:0]                  pred_target_i;
    logic                         pred_ready_o;
    logic                         res_valid_i;
    logic                         res_taken_i;
    logic [31:0]                  res_target_i;
    logic                         upd_valid_o;
    logic                         upd_miss_o;
    logic                         redirect_o;
    logic [31:0]                  redirect_pc_o;
    logic                         flush_o;
    logic [$clog2(DEPTH+1)-1:0]   inflight_o;

    modport master (
        output pred_valid_i, pred_taken_i, pred_pc_i, pred_target_i,
        output res_valid_i, res_taken_i, res_target_i,
        input  pred_ready_o, upd_valid_o, upd_miss_o, redirect_o,
        input  redirect_pc_o, flush_o, inflight_o
    );

    modport slave (
        input  pred_valid_i, pred_taken_i, pred_pc_i, pred_target_i,
        input  res_valid_i, res_taken_i, res_target_i,
        output pred_ready_o, upd_valid_o, upd_miss_o, redirect_o,
        output redirect_pc_o, flush_o, inflight_o
    );
endinterface

// File: rtl/br_resolve_ctrl.sv
// In-order queue of fetch branch predictions checked against execute resolution.
// Drives predictor training, fetch redirect and a timed flush. Define BR_CTRL_STATS_EN for stat counters.
module br_resolve_ctrl #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef BR_CTRL_STATS_EN
    output logic [31:0] stat_resolved_o,
    output logic [31:0] stat_miss_o,
    output logic        stat_err_o,
`endif
    br_resolve_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state_q;
    logic [FC_W-1:0]  fcnt_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;

    logic [31:0] q_pc     [DEPTH];
    logic        q_taken  [DEPTH];
    logic [31:0] q_target [DEPTH];

    logic        upd_vld_p1;
    logic        upd_miss_p1;
    logic        redir_p1;
    logic [31:0] redir_pc_p1;

    logic run;
    logic pred_ready;
    logic res_fire;
    logic mispred;
    logic push;
    logic pop;
    logic head_taken;
    logic [31:0] head_target;

    // The branch PC is carried for each in-flight record; nothing consumes it yet.
    logic unused_head_pc;

    assign run            = (state_q == ST_RUN);
    assign pred_ready     = run && (count_q != FULL_CNT);
    assign head_taken     = q_taken[rd_ptr_q];
    assign head_target    = q_target[rd_ptr_q];
    assign unused_head_pc = ^q_pc[rd_ptr_q];

    assign res_fire = run && bus.res_valid_i && (count_q != '0);
    assign mispred  = res_fire &&
                      ((bus.res_taken_i != head_taken) || (bus.res_target_i != head_target));
    assign push     = bus.pred_valid_i && pred_ready;
    assign pop      = res_fire && !mispred;

    // p0 -> p1: queue bookkeeping, flush sequencing and registered resolution outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            fcnt_q      <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            upd_vld_p1  <= 1'b0;
            upd_miss_p1 <= 1'b0;
            redir_p1    <= 1'b0;
            redir_pc_p1 <= '0;
        end else begin
            upd_vld_p1  <= res_fire;
            upd_miss_p1 <= mispred;
            redir_p1    <= mispred;
            if (mispred) begin
                redir_pc_p1 <= bus.res_target_i;
            end

            if (mispred) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                state_q  <= ST_FLUSH;
                fcnt_q   <= FLUSH_LAST;
            end else if (state_q == ST_FLUSH) begin
                if (fcnt_q == '0) begin
                    state_q <= ST_RUN;
                end else begin
                    fcnt_q <= fcnt_q - FC_W'(1);
                end
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Entry storage is plain data; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !mispred) begin
            q_pc[wr_ptr_q]     <= bus.pred_pc_i;
            q_taken[wr_ptr_q]  <= bus.pred_taken_i;
            q_target[wr_ptr_q] <= bus.pred_target_i;
        end
    end

    assign bus.pred_ready_o  = pred_ready;
    assign bus.upd_valid_o   = upd_vld_p1;
    assign bus.upd_miss_o    = upd_miss_p1;
    assign bus.redirect_o    = redir_p1;
    assign bus.redirect_pc_o = redir_pc_p1;
    assign bus.flush_o       = (state_q == ST_FLUSH);
    assign bus.inflight_o    = count_q;

`ifdef BR_CTRL_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // p1 -> p2: statistics follow the registered training strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_resolved_o <= '0;
            stat_miss_o     <= '0;
            stat_err_o      <= 1'b0;
        end else begin
            if (upd_vld_p1) begin
                stat_resolved_o <= sat_inc(stat_resolved_o);
            end
            if (upd_vld_p1 && upd_miss_p1) begin
                stat_miss_o <= sat_inc(stat_miss_o);
            end
            if (run && bus.res_valid_i && (count_q == '0)) begin
                stat_err_o <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Scoreboard bench for br_resolve_ctrl: stimulus queues expected training events, a monitor checks them.
module tb_br_resolve_ctrl;
    localparam int DEPTH = 4;
    localparam int FC    = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    br_resolve_if #(.DEPTH(DEPTH)) bus ();

`ifdef BR_CTRL_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_miss;
    logic        stat_err;
`endif

    br_resolve_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
`ifdef BR_CTRL_STATS_EN
        .stat_resolved_o (stat_resolved),
        .stat_miss_o     (stat_miss),
        .stat_err_o      (stat_err),
`endif
        .bus             (bus)
    );

    typedef struct packed {
        logic        miss;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every training strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && bus.upd_valid_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL upd_unexpected actual=upd_valid_o=1 required=no update");
            end else begin
                mon_e = sb.pop_front();
                if (bus.upd_miss_o !== mon_e.miss || bus.redirect_o !== mon_e.miss ||
                    (mon_e.miss && bus.redirect_pc_o !== mon_e.pc)) begin
                    errors++;
                    $display("FAIL upd_event actual miss=%0b redir=%0b pc=0x%0h required miss=%0b redir=%0b pc=0x%0h",
                             bus.upd_miss_o, bus.redirect_o, bus.redirect_pc_o,
                             mon_e.miss, mon_e.miss, mon_e.pc);
                end
            end
        end else if (reset_n && bus.redirect_o) begin
            checks++;
            errors++;
            $display("FAIL redirect_alone actual=redirect_o=1 required=0 without upd_valid_o");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        bus.pred_valid_i  = 1'b1;
        bus.pred_pc_i     = pc;
        bus.pred_taken_i  = tk;
        bus.pred_target_i = tg;
        tick();
        bus.pred_valid_i  = 1'b0;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tg, input logic exp_miss);
        bus.res_valid_i  = 1'b1;
        bus.res_taken_i  = tk;
        bus.res_target_i = tg;
        sb.push_back({exp_miss, tg});
        tick();
        bus.res_valid_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("timeout: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.pred_valid_i  = 1'b0;
        bus.pred_taken_i  = 1'b0;
        bus.pred_pc_i     = '0;
        bus.pred_target_i = '0;
        bus.res_valid_i   = 1'b0;
        bus.res_taken_i   = 1'b0;
        bus.res_target_i  = '0;

        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",    bus.pred_ready_o,  1);
        chk("rst_inflight", bus.inflight_o,    0);
        chk("rst_upd",      bus.upd_valid_o,   0);
        chk("rst_miss",     bus.upd_miss_o,    0);
        chk("rst_redirect", bus.redirect_o,    0);
        chk("rst_redir_pc", bus.redirect_pc_o, 0);
        chk("rst_flush",    bus.flush_o,       0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Correct prediction round trip
        push(32'h100, 1'b1, 32'h140);
        chk("t1_inflight_1", bus.inflight_o, 1);
        resolve(1'b1, 32'h140, 1'b0);
        chk("t1_inflight_0", bus.inflight_o, 0);
        chk("t1_redirect",   bus.redirect_o, 0);
        chk("t1_flush",      bus.flush_o,    0);
        tick();
        chk("t1_upd_pulse",  bus.upd_valid_o, 0);

        // Mispredict on target with three in flight
        push(32'h200, 1'b1, 32'h140);
        push(32'h204, 1'b0, 32'h208);
        push(32'h208, 1'b1, 32'h300);
        chk("t2_inflight_3", bus.inflight_o, 3);
        resolve(1'b1, 32'h104, 1'b1);
        chk("t2_flush_n1",   bus.flush_o,      1);
        chk("t2_inflight_0", bus.inflight_o,   0);
        chk("t2_ready_n1",   bus.pred_ready_o, 0);
        tick();
        chk("t2_flush_n2",   bus.flush_o,       1);
        chk("t2_ready_n2",   bus.pred_ready_o,  0);
        chk("t2_redir_off",  bus.redirect_o,    0);
        chk("t2_redir_hold", bus.redirect_pc_o, 32'h104);
        tick();
        chk("t2_flush_n3",   bus.flush_o,      0);
        chk("t2_ready_n3",   bus.pred_ready_o, 1);

        // Fill to DEPTH, then pop with a same-cycle push
        push(32'h300, 1'b0, 32'h304);
        push(32'h304, 1'b0, 32'h308);
        push(32'h308, 1'b0, 32'h30c);
        push(32'h30c, 1'b0, 32'h310);
        chk("t3_inflight_4", bus.inflight_o,   4);
        chk("t3_ready_full", bus.pred_ready_o, 0);
        bus.pred_valid_i  = 1'b1;
        bus.pred_pc_i     = 32'h310;
        bus.pred_taken_i  = 1'b0;
        bus.pred_target_i = 32'h314;
        bus.res_valid_i   = 1'b1;
        bus.res_taken_i   = 1'b0;
        bus.res_target_i  = 32'h304;
        sb.push_back({1'b0, 32'h304});
        tick();
        bus.res_valid_i   = 1'b0;
        chk("t3_no_bypass",  bus.inflight_o,   3);
        chk("t3_ready_back", bus.pred_ready_o, 1);
        tick();
        bus.pred_valid_i  = 1'b0;
        chk("t3_refill_4",   bus.inflight_o,   4);

        // Correct pop, then mispredict (taken mismatch) with a dropped push
        resolve(1'b0, 32'h308, 1'b0);
        chk("t4_inflight_3", bus.inflight_o, 3);
        bus.pred_valid_i  = 1'b1;
        bus.pred_pc_i     = 32'h700;
        bus.pred_taken_i  = 1'b0;
        bus.pred_target_i = 32'h704;
        bus.res_valid_i   = 1'b1;
        bus.res_taken_i   = 1'b1;
        bus.res_target_i  = 32'h500;
        sb.push_back({1'b1, 32'h500});
        tick();
        chk("t4_push_drop",  bus.inflight_o, 0);
        chk("t4_flush",      bus.flush_o,    1);
        bus.res_target_i  = 32'h30c;
        bus.res_taken_i   = 1'b0;
        tick();
        bus.pred_valid_i  = 1'b0;
        bus.res_valid_i   = 1'b0;
        chk("t4_flush_ignore_res", bus.upd_valid_o, 0);
        chk("t4_flush_ignore_pred", bus.inflight_o, 0);
        tick();
        chk("t4_flush_done", bus.flush_o,      0);
        chk("t4_ready",      bus.pred_ready_o, 1);

        // Resolve against an empty queue
        bus.res_valid_i  = 1'b1;
        bus.res_taken_i  = 1'b0;
        bus.res_target_i = 32'h0;
        tick();
        bus.res_valid_i  = 1'b0;
        chk("empty_res_upd",      bus.upd_valid_o, 0);
        chk("empty_res_inflight", bus.inflight_o,  0);

`ifdef BR_CTRL_STATS_EN
        chk("stat_resolved", stat_resolved, 5);
        chk("stat_miss",     stat_miss,     2);
        chk("stat_err",      stat_err,      1);
`endif

        // Reset asserted during the first flush cycle
        push(32'h600, 1'b1, 32'h640);
        resolve(1'b0, 32'h604, 1'b1);
        chk("t5_flush_pre",    bus.flush_o,    1);
        chk("t5_redirect_pre", bus.redirect_o, 1);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t5_flush_rst",    bus.flush_o,      0);
        chk("t5_redirect_rst", bus.redirect_o,   0);
        chk("t5_upd_rst",      bus.upd_valid_o,  0);
        chk("t5_inflight_rst", bus.inflight_o,   0);
        chk("t5_ready_rst",    bus.pred_ready_o, 1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        push(32'h800, 1'b0, 32'h804);
        chk("t6_inflight_1", bus.inflight_o, 1);
        resolve(1'b0, 32'h804, 1'b0);
        chk("t6_inflight_0", bus.inflight_o, 0);
        tick();
        tick();

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
